ad9783_spi_responder: RTL

Synthesizable SPI responder that emulates the AD9783 DAC serial-port register map inside the FPGA. It is the far end of the AD9783 driver's SPI initiator and lets that driver, and the DAC bring-up firmware, run closed-loop on hardware with no DAC fitted. It oversamples `spi_scs_in`, `spi_sck_in` and `spi_sdi_in` in the `clk_in` domain. It decodes AD9783 instruction bytes, maintains a 32 x 8 register file, returns read data on `spi_sdo_out`, and reports every committed write to local logic.

---
 rtl/ad9783_spi_responder_pkg.sv | 29 ++
 rtl/ad9783_spi_responder_edge_sync.sv | 69 ++++++
 rtl/ad9783_spi_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ad9783_spi_responder_pkg.sv
// Shared definitions for the AD9783 serial-port responder:
// instruction fields, FSM states and power-on register contents.
package ad9783_resp_pkg;

  localparam int RW_BIT   = 7;
  localparam int N_MSB    = 6;
  localparam int N_LSB    = 5;
  localparam int ADDR_MSB = 4;
  localparam int ADDR_LSB = 0;
  localparam int AW       = 5;

  localparam int SOFTRESET_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INSTR,
    ST_DATA,
    ST_DONE
  } resp_state_t;

  // 0x1F holds the version ID; everything else powers up cleared
  localparam logic [7:0] AD9783_REG_DEFAULTS [0:31] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03
  };

endpackage

// File: rtl/ad9783_spi_responder_edge_sync.sv
// SPI pin synchronizers with registered single-cycle edge pulses
// for sck rise/fall and scs fall/rise, plus the aligned sdi bit.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic scs_i,
  input  logic sck_i,
  input  logic sdi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic scs_fall_o,
  output logic scs_rise_o,
  output logic sdi_o
);

  logic [SYNC_STAGES-1:0] scs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic scs_prev_q;
  logic sck_prev_q;
  logic sck_rise_q;
  logic sck_fall_q;
  logic scs_fall_q;
  logic scs_rise_q;
  logic sdi_q;

  logic scs_s;
  logic sck_s;

  assign scs_s = scs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];

  // scs chain clears to 0 so a select held low across reset
  // never looks like a fresh falling edge
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      scs_sync_q <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      scs_prev_q <= 1'b0;
      sck_prev_q <= 1'b0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      scs_fall_q <= 1'b0;
      scs_rise_q <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      scs_sync_q <= {scs_sync_q[SYNC_STAGES-2:0], scs_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      scs_prev_q <= scs_s;
      sck_prev_q <= sck_s;
      sck_rise_q <= sck_s & ~sck_prev_q;
      sck_fall_q <= ~sck_s & sck_prev_q;
      scs_fall_q <= ~scs_s & scs_prev_q;
      scs_rise_q <= scs_s & ~scs_prev_q;
      sdi_q      <= sdi_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise_o = sck_rise_q;
  assign sck_fall_o = sck_fall_q;
  assign scs_fall_o = scs_fall_q;
  assign scs_rise_o = scs_rise_q;
  assign sdi_o      = sdi_q;

endmodule

// File: rtl/ad9783_spi_responder.sv
// AD9783 SPI register-map responder (32 x 8, mode 0, MSB first).
// Define AD9783_RESP_SOFTRESET_EN for the self-clearing reg 0x00 bit5 reset.
module ad9783_spi_responder
  import ad9783_resp_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          spi_scs_in,
  input  logic          spi_sck_in,
  input  logic          spi_sdi_in,
  output logic          spi_sdo_out,
  output logic          spi_sdo_oe_out,
  output logic          wr_stb_out,
  output logic [AW-1:0] wr_addr_out,
  output logic [7:0]    wr_data_out,
  input  logic [AW-1:0] peek_addr_in,
  output logic [7:0]    peek_data_out,
  output logic          busy_out
);

  logic sck_rise;
  logic sck_fall;
  logic scs_fall;
  logic scs_rise;
  logic sdi_s;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .scs_i      (spi_scs_in),
    .sck_i      (spi_sck_in),
    .sdi_i      (spi_sdi_in),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .scs_fall_o (scs_fall),
    .scs_rise_o (scs_rise),
    .sdi_o      (sdi_s)
  );

  resp_state_t state_q, state_d;

  logic [7:0]    regs_q [NREGS];
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rw_q, rw_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]    sdo_sr_q, sdo_sr_d;
  logic          oe_q, oe_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          busy_q;
  logic [7:0]    peek_q;
  logic          we;
  logic          soft_rst;
  logic [7:0]    byte_in;
  logic          last_bit;

  assign byte_in  = {shift_q[6:0], sdi_s};
  assign last_bit = sck_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scs_rise) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (scs_fall) state_d = ST_INSTR;
        ST_INSTR: if (last_bit) state_d = ST_DATA;
        ST_DATA:  if (last_bit && byte_cnt_q == 2'd0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    byte_cnt_d = byte_cnt_q;
    cur_addr_d = cur_addr_q;
    sdo_sr_d   = sdo_sr_q;
    oe_d       = oe_q;
    stb_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we         = 1'b0;
    if (!scs_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          sdo_sr_d  = 8'h00;
          oe_d      = 1'b0;
        end
        ST_INSTR: begin
          oe_d = 1'b0;
          if (sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (last_bit) begin
            rw_d       = byte_in[RW_BIT];
            byte_cnt_d = byte_in[N_MSB:N_LSB];
            cur_addr_d = byte_in[ADDR_MSB:ADDR_LSB];
          end
        end
        ST_DATA: begin
          if (sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (last_bit) begin
            we         = !rw_q;
            stb_d      = !rw_q;
            waddr_d    = rw_q ? waddr_q : cur_addr_q;
            wdata_d    = rw_q ? wdata_q : byte_in;
            cur_addr_d = cur_addr_q - 5'd1;
            byte_cnt_d = byte_cnt_q - 2'd1;
          end else if (sck_fall && rw_q) begin
            // the fall closing the previous byte preloads the next one
            if (bit_cnt_q == 3'd0) begin
              sdo_sr_d = regs_q[cur_addr_q];
              oe_d     = 1'b1;
            end else begin
              sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
            end
          end
        end
        ST_DONE: oe_d = 1'b0;
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      byte_cnt_q <= 2'd0;
      cur_addr_q <= '0;
      sdo_sr_q   <= 8'h00;
      oe_q       <= 1'b0;
      stb_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      peek_q     <= 8'h00;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      byte_cnt_q <= byte_cnt_d;
      cur_addr_q <= cur_addr_d;
      sdo_sr_q   <= sdo_sr_d;
      oe_q       <= oe_d;
      stb_q      <= stb_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= (state_d != ST_IDLE);
      peek_q     <= regs_q[peek_addr_in];
    end
  end

`ifdef AD9783_RESP_SOFTRESET_EN
  assign soft_rst = stb_q && (waddr_q == '0) && wdata_q[SOFTRESET_BIT];
`else
  assign soft_rst = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in || soft_rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= AD9783_REG_DEFAULTS[i];
    end else if (we) begin
      regs_q[cur_addr_q] <= byte_in;
    end
  end

  assign spi_sdo_out    = sdo_sr_q[7];
  assign spi_sdo_oe_out = oe_q;
  assign wr_stb_out     = stb_q;
  assign wr_addr_out    = waddr_q;
  assign wr_data_out    = wdata_q;
  assign peek_data_out  = peek_q;
  assign busy_out       = busy_q;

endmodule
